// File: rtl/mandel_pkg.sv
// rtl/mandel_pkg.sv - shared defaults, coordinate widths and scheduler state type
package mandel_pkg;
  localparam int X_SIZE_DEF  = 640;
  localparam int Y_SIZE_DEF  = 480;
  localparam int X_W         = 10;
  localparam int Y_W         = 9;
  localparam int DEPTH_W_DEF = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;
endpackage

// File: rtl/mandel_raster_counter.sv
// rtl/mandel_raster_counter.sv - raster-order (x,y) walker over one frame
module raster_counter
  import mandel_pkg::*;
#(
  parameter int X_SIZE = X_SIZE_DEF,
  parameter int Y_SIZE = Y_SIZE_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           advance,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           first,
  output logic           lastx,
  output logic           last
);
  assign first = (x == '0) && (y == '0);
  assign lastx = (x == X_W'(X_SIZE - 1));
  assign last  = lastx && (y == Y_W'(Y_SIZE - 1));

  // Wraps to (0,0) after the final pixel so the next frame needs no explicit clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (lastx) begin
        x <= '0;
        y <= last ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end
endmodule

// File: rtl/mandel_dispatch_scheduler.sv
// rtl/mandel_dispatch_scheduler.sv - round-robin engine dispatch with in-order raster retire
// Optional perf counters: MANDEL_SCHED_PERF_EN
module mandel_dispatch_scheduler
  import mandel_pkg::*;
#(
  parameter int N_ENGINES = 4,
  parameter int X_SIZE    = X_SIZE_DEF,
  parameter int Y_SIZE    = Y_SIZE_DEF,
  parameter int DEPTH_W   = DEPTH_W_DEF
) (
  input  logic                           out_stream_aclk,
  input  logic                           periph_resetn,
  input  logic                           run,
  output logic [N_ENGINES-1:0]           eng_start,
  output logic [X_W-1:0]                 eng_x,
  output logic [Y_W-1:0]                 eng_y,
  input  logic [N_ENGINES-1:0]           eng_done,
  input  logic [N_ENGINES*DEPTH_W-1:0]   eng_depth,
  output logic [N_ENGINES-1:0]           eng_ack,
  output logic                           pix_valid,
  input  logic                           pix_ready,
  output logic [DEPTH_W-1:0]             pix_depth,
  output logic [X_W-1:0]                 pix_x,
  output logic [Y_W-1:0]                 pix_y,
  output logic                           pix_sof,
  output logic                           pix_eol,
  output logic                           frame_done
`ifdef MANDEL_SCHED_PERF_EN
  ,
  output logic [31:0]                    perf_frame_cycles,
  output logic [31:0]                    perf_stall_cycles
`endif
);
  localparam int PW = (N_ENGINES > 1) ? $clog2(N_ENGINES) : 1;

  sched_state_t         state;
  logic [N_ENGINES-1:0] occ;
  logic [PW-1:0]        iss_ptr, ret_ptr;
  logic [Y_W-1:0]       ret_y;
  logic [X_W-1:0]       ret_x;
  logic                 ret_first, ret_lastx, ret_last, iss_last;
  logic                 unused_iss_first, unused_iss_lastx;
  logic                 pix_last, dispatch, retire, accept;

  // Pixel n always lands on engine n mod N, so retiring in pointer order is raster order.
  assign dispatch = (state == ISSUE) && !occ[iss_ptr];
  assign accept   = pix_valid && pix_ready;
  assign retire   = occ[ret_ptr] && eng_done[ret_ptr] && (!pix_valid || pix_ready);

  always_comb begin
    eng_start = '0;
    if (dispatch) eng_start[iss_ptr] = 1'b1;
  end

  raster_counter #(.X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE)) u_iss_cnt (
    .clk(out_stream_aclk), .rst_n(periph_resetn), .advance(dispatch),
    .x(eng_x), .y(eng_y), .first(unused_iss_first), .lastx(unused_iss_lastx), .last(iss_last)
  );

  raster_counter #(.X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE)) u_ret_cnt (
    .clk(out_stream_aclk), .rst_n(periph_resetn), .advance(retire),
    .x(ret_x), .y(ret_y), .first(ret_first), .lastx(ret_lastx), .last(ret_last)
  );

  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      state      <= IDLE;
      occ        <= '0;
      iss_ptr    <= '0;
      ret_ptr    <= '0;
      eng_ack    <= '0;
      pix_valid  <= 1'b0;
      pix_depth  <= '0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_sof    <= 1'b0;
      pix_eol    <= 1'b0;
      pix_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      eng_ack    <= '0;
      frame_done <= 1'b0;
      case (state)
        IDLE:    if (run) state <= ISSUE;
        ISSUE:   if (dispatch && iss_last) state <= DRAIN;
        DRAIN:   if (accept && pix_last) begin
                   state      <= IDLE;
                   frame_done <= 1'b1;
                 end
        default: state <= IDLE;
      endcase
      // Dispatch needs occ=0 and retire needs occ=1, so the two never touch the same bit.
      if (dispatch) begin
        occ[iss_ptr] <= 1'b1;
        iss_ptr      <= (iss_ptr == PW'(N_ENGINES - 1)) ? '0 : iss_ptr + 1'b1;
      end
      if (retire) begin
        occ[ret_ptr]     <= 1'b0;
        eng_ack[ret_ptr] <= 1'b1;
        ret_ptr          <= (ret_ptr == PW'(N_ENGINES - 1)) ? '0 : ret_ptr + 1'b1;
        pix_valid        <= 1'b1;
        pix_depth        <= eng_depth[ret_ptr*DEPTH_W +: DEPTH_W];
        pix_x            <= ret_x;
        pix_y            <= ret_y;
        pix_sof          <= ret_first;
        pix_eol          <= ret_lastx;
        pix_last         <= ret_last;
      end else if (accept) begin
        pix_valid <= 1'b0;
      end
    end
  end

`ifdef MANDEL_SCHED_PERF_EN
  logic [31:0] frame_cnt, stall_cnt;

  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      frame_cnt         <= '0;
      stall_cnt         <= '0;
      perf_frame_cycles <= '0;
      perf_stall_cycles <= '0;
    end else if (state == IDLE) begin
      frame_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + 1'b1;
      if (pix_valid && !pix_ready) stall_cnt <= stall_cnt + 1'b1;
      if (state == DRAIN && accept && pix_last) begin
        perf_frame_cycles <= frame_cnt + 1'b1;
        perf_stall_cycles <= stall_cnt;
      end
    end
  end
`endif
endmodule

// File: tb/tb_mandel_dispatch_scheduler.sv
// tb/tb_mandel_dispatch_scheduler.sv - randomized bench with engine stubs and raster-order model
module tb_mandel_dispatch_scheduler;
  localparam int N = 4, XS = 8, YS = 2, DW = 10, NPIX = XS * YS;

  logic          clk = 1'b0, resetn = 1'b1, run = 1'b0, pix_ready = 1'b1, spur2 = 1'b0;
  logic [N-1:0]  eng_start, eng_ack, eng_done, st_done = '0;
  logic [N*DW-1:0] eng_depth;
  logic [9:0]    eng_x, pix_x;
  logic [8:0]    eng_y, pix_y;
  logic [DW-1:0] pix_depth;
  logic          pix_valid, pix_sof, pix_eol, frame_done;
  logic [DW-1:0] dep [N];
  int            busy [N], cnt [N];

  int n_checks = 0, n_fail = 0, cyc = 0, rcnt = 0;
  int lat_mode = 1, ready_mode = 0;
  int iss_idx = 0, out_idx = 0, ack_idx = 0, fd_count = 0;
  int sof_count = 0, eol_count = 0, spur_ack = 0, spur_valid = 0;
  int fd_cyc = 0, gap = -1, gap_wait = 0, first_x = -1, first_y = -1, want_first = 0;
  int cap_x = -1, cap_y = -1, cap_d = -1, cap0_sof = -1;
  logic exp_fd = 1'b0, hold = 1'b0;
  logic [9:0] hx; logic [8:0] hy; logic [DW-1:0] hd; logic hs, he;

  assign eng_done  = st_done | (spur2 ? 4'b0100 : 4'b0000);
  assign eng_depth = {dep[3], dep[2], dep[1], dep[0]};

  mandel_dispatch_scheduler #(.N_ENGINES(N), .X_SIZE(XS), .Y_SIZE(YS), .DEPTH_W(DW)) dut (
    .out_stream_aclk(clk), .periph_resetn(resetn), .run(run),
    .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y),
    .eng_done(eng_done), .eng_depth(eng_depth), .eng_ack(eng_ack),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_depth(pix_depth),
    .pix_x(pix_x), .pix_y(pix_y), .pix_sof(pix_sof), .pix_eol(pix_eol),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int latency(input int k);
    case (lat_mode)
      1:       return 3;
      2:       return (k == 0) ? 20 : 1;
      default: return int'($urandom_range(1, 6));
    endcase
  endfunction

  always @(posedge clk) begin
    #1;
    rcnt++;
    case (ready_mode)
      0:       pix_ready = 1'b1;
      1:       pix_ready = (rcnt >= 20 && rcnt < 30) ? 1'b0 : 1'(rcnt % 2);
      default: pix_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Mid-cycle: compare DUT against the raster model, then advance the engine stubs.
  always @(negedge clk) begin
    if (!resetn) begin
      st_done = '0;
      for (int k = 0; k < N; k++) begin busy[k] = 0; cnt[k] = 0; end
      hold = 1'b0; exp_fd = 1'b0;
    end else begin
      chk("frame_done", frame_done, exp_fd);
      exp_fd = 1'b0;
      if (frame_done) begin fd_count++; fd_cyc = cyc; gap_wait = 1; end
      if (spur2) begin
        if (eng_ack[2]) spur_ack++;
        if (pix_valid) spur_valid++;
      end
      if (eng_start != '0) begin
        automatic int k = iss_idx % N, p = iss_idx % NPIX;
        chk("start_engine", eng_start, 1 << k);
        chk("start_x", eng_x, p % XS);
        chk("start_y", eng_y, p / XS);
        chk("start_free", (busy[k] == 0) && (!st_done[k] || eng_ack[k]), 1);
        if (gap_wait) begin gap = cyc - fd_cyc; gap_wait = 0; end
        if (want_first) begin first_x = eng_x; first_y = eng_y; want_first = 0; end
        iss_idx++;
      end
      if (eng_ack != '0) begin
        chk("ack_engine", eng_ack, 1 << (ack_idx % N));
        chk("ack_has_result", (eng_ack & st_done) == eng_ack, 1);
        ack_idx++;
      end
      if (hold) begin
        chk("hold_valid", pix_valid, 1);
        chk("hold_data", {pix_x, pix_y, pix_depth, pix_sof, pix_eol}, {hx, hy, hd, hs, he});
      end
      if (pix_valid) begin
        automatic int p = out_idx % NPIX;
        chk("pix_x", pix_x, p % XS);
        chk("pix_y", pix_y, p / XS);
        chk("pix_depth", pix_depth, p % XS + XS * (p / XS));
        chk("pix_sof", pix_sof, p == 0);
        chk("pix_eol", pix_eol, (p % XS) == XS - 1);
        if (pix_ready) begin
          if (out_idx == 0) cap0_sof = pix_sof;
          if (out_idx == 9) begin cap_x = pix_x; cap_y = pix_y; cap_d = pix_depth; end
          if (pix_sof) sof_count++;
          if (pix_eol) eol_count++;
          out_idx++;
          if (out_idx % NPIX == 0) exp_fd = 1'b1;
        end
      end
      hold = pix_valid && !pix_ready;
      hx = pix_x; hy = pix_y; hd = pix_depth; hs = pix_sof; he = pix_eol;
      for (int k = 0; k < N; k++) begin
        if (eng_ack[k]) st_done[k] = 1'b0;
        if (eng_start[k]) begin
          busy[k] = 1; cnt[k] = latency(k); dep[k] = DW'(eng_x + XS * eng_y);
        end else if (busy[k] != 0) begin
          cnt[k]--;
          if (cnt[k] == 0) begin busy[k] = 0; st_done[k] = 1'b1; end
        end
      end
    end
  end

  task automatic pulse_run();
    @(posedge clk); #1 run = 1'b1;
    @(posedge clk); #1 run = 1'b0;
  endtask

  task automatic wait_fd(input int target, input int budget);
    int c = 0;
    while (fd_count < target && c < budget) begin @(posedge clk); c++; end
    chk("frame_wait", fd_count >= target, 1);
  endtask

  task automatic reset_checks();
    chk("rst_eng_start", eng_start, 0);
    chk("rst_eng_ack", eng_ack, 0);
    chk("rst_eng_xy", {eng_x, eng_y}, 0);
    chk("rst_pix", {pix_valid, pix_x, pix_y, pix_depth, pix_sof, pix_eol}, 0);
    chk("rst_frame_done", frame_done, 0);
  endtask

  task automatic do_reset();
    resetn = 1'b0; #1;
    reset_checks();
    iss_idx = 0; out_idx = 0; ack_idx = 0;
    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;
  endtask

  initial begin
    int base, c;
    #2 do_reset();

    // Fixed 3-cycle engines, always ready.
    lat_mode = 1; ready_mode = 0;
    pulse_run();
    wait_fd(1, 400);
    chk("t1_pixels", out_idx, 16);
    chk("t1_sof_count", sof_count, 1);
    chk("t1_eol_count", eol_count, 2);
    chk("t1_pix0_sof", cap0_sof, 1);
    chk("t1_pix9_x", cap_x, 1);
    chk("t1_pix9_y", cap_y, 1);
    chk("t1_pix9_depth", cap_d, 9);
    base = iss_idx;
    repeat (6) @(posedge clk);
    chk("t1_idle_no_start", iss_idx, base);
    chk("t1_one_frame_done", fd_count, 1);

    // Slow engine 0 must not let later engines retire ahead of it.
    lat_mode = 2;
    pulse_run();
    wait_fd(2, 600);
    chk("t2_pixels", out_idx, 32);

    // Toggling ready with a 10-cycle low burst.
    lat_mode = 0; ready_mode = 1; rcnt = 0;
    pulse_run();
    wait_fd(3, 800);
    chk("t3_pixels", out_idx, 48);

    // run held high: next frame restarts the cycle after frame_done.
    ready_mode = 2;
    @(posedge clk); #1 run = 1'b1;
    wait_fd(4, 800);
    repeat (3) @(posedge clk);
    #1 run = 1'b0;
    chk("t4_restart_gap", gap, 1);
    wait_fd(5, 800);
    chk("t4_pixels", out_idx, 80);
    base = iss_idx;
    repeat (6) @(posedge clk);
    chk("t4_stopped", iss_idx, base);

    // Reset in the middle of a frame.
    pulse_run();
    base = out_idx; c = 0;
    while (out_idx < base + 5 && c < 400) begin @(posedge clk); c++; end
    chk("t5_reached_pixel5", out_idx >= base + 5, 1);
    @(posedge clk); #2;
    do_reset();
    want_first = 1;
    pulse_run();
    wait_fd(fd_count + 1, 800);
    chk("t5_first_x", first_x, 0);
    chk("t5_first_y", first_y, 0);
    chk("t5_pixels", out_idx, 16);

    // Spurious done on an unoccupied engine.
    repeat (3) @(posedge clk);
    #1 spur2 = 1'b1;
    repeat (8) @(posedge clk);
    #1 spur2 = 1'b0;
    chk("t6_spur_ack", spur_ack, 0);
    chk("t6_spur_valid", spur_valid, 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mandel_dispatch_scheduler.md
Name: mandel_dispatch_scheduler

Overview:
- Shares N_ENGINES Mandelbrot depth-calculator engines across one raster frame.
- Issues pixel coordinates to idle engines in round-robin order.
- Collects depths in the same order and presents them as an in-order raster stream to the colour LUT / packer stage.
- Sits between the pixel-coordinate generator and the packer; replaces single-engine start/done sequencing.

Parameters:
- N_ENGINES, 4, number of engines; power of two, 1..16.
- X_SIZE, 640, pixels per line.
- Y_SIZE, 480, lines per frame.
- DEPTH_W, 10, width of engine depth result.

Ports:
- out_stream_aclk  in  1  clock.
- periph_resetn  in  1  asynchronous active-low reset.
- run  in  1  allow a new frame to start.
- eng_start  out  N_ENGINES  one-cycle start pulse per engine.
- eng_x  out  10  pixel x broadcast to engines; valid with any eng_start bit.
- eng_y  out  9  pixel y broadcast to engines; valid with any eng_start bit.
- eng_done  in  N_ENGINES  level; engine k holds result until acked.
- eng_depth  in  N_ENGINES*DEPTH_W  engine k depth at slice [k*DEPTH_W +: DEPTH_W].
- eng_ack  out  N_ENGINES  one-cycle pulse; engine k drops done next cycle.
- pix_valid  out  1  output pixel valid.
- pix_ready  in  1  downstream ready.
- pix_depth  out  DEPTH_W  depth of output pixel.
- pix_x  out  10  x of output pixel.
- pix_y  out  9  y of output pixel.
- pix_sof  out  1  output pixel is (0,0).
- pix_eol  out  1  output pixel x == X_SIZE-1.
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted.

Behaviour:
- Reset (async assert, sync release): all outputs 0; issue/retire pointers 0; occupancy bits 0; issue coordinate (0,0); retire coordinate (0,0); FSM IDLE.
- FSM states:
  - IDLE: enter ISSUE when run=1.
  - ISSUE: dispatch and retire run concurrently; after the last pixel (X_SIZE-1, Y_SIZE-1) is dispatched, go to DRAIN.
  - DRAIN: retire only; after the last pixel is accepted, pulse frame_done and go to IDLE.
- run is sampled only in IDLE. Deasserting run mid-frame does not stop the current frame.
- Dispatch: in ISSUE, if occ[iss_ptr]=0, then in the same cycle:
  - pulse eng_start[iss_ptr] with eng_x/eng_y = issue coordinate;
  - set occ[iss_ptr];
  - advance iss_ptr mod N_ENGINES;
  - advance the issue coordinate in raster order (x wraps at X_SIZE-1 and increments y).
  - At most one dispatch per cycle. Dispatch stalls while occ[iss_ptr]=1.
- Retire: if occ[ret_ptr]=1 and eng_done[ret_ptr]=1 and the output register is empty or being consumed (pix_valid=0 or pix_ready=1), then on the next edge:
  - load pix_depth from slice ret_ptr;
  - load pix_x/pix_y/pix_sof/pix_eol from the retire coordinate;
  - set pix_valid;
  - pulse eng_ack[ret_ptr];
  - clear occ[ret_ptr];
  - advance ret_ptr and the retire coordinate.
- Latency: done to pix_valid is 1 cycle.
- Output stage is a single skid-free register; a new load is permitted in the same cycle pix_ready accepts the current pixel (full throughput).
- pix_valid, once high, holds with stable data until pix_ready=1.
- Same-engine dispatch and retire in one cycle: retire clears occ, and dispatch to that engine is deferred to the following cycle (dispatch uses the registered occ only).
- eng_done on an unoccupied engine is ignored. No ack is issued for it.
- Order guarantee: pixel n is processed by engine n mod N_ENGINES, so retire order equals raster order with no reorder buffer.
- Reset mid-frame: all state is cleared immediately. Engines share periph_resetn, so no stale done is accepted.

Optional Feature:
- Macro: MANDEL_SCHED_PERF_EN.
- When defined, two extra output ports:
  - perf_frame_cycles (32 bits): cycles from the IDLE->ISSUE transition to frame_done; latched at frame_done.
  - perf_stall_cycles (32 bits): cycles with pix_valid=1 and pix_ready=0 within the frame; latched at frame_done.
  - Both outputs reset to 0.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package mandel_pkg: X_SIZE/Y_SIZE defaults, coordinate widths (10/9), DEPTH_W, and the scheduler state enum (IDLE, ISSUE, DRAIN).
- Sub-module raster_counter:
  - inputs: clock, reset, advance;
  - outputs: x, y, first, lastx, last;
  - instantiated twice (issue coordinate, retire coordinate).

Test Plan:
- N=4, 8x2 frame, engines with fixed 3-cycle latency, pix_ready=1 -> 16 pixels out in raster order; pix_sof only at (0,0); pix_eol at x=7; exactly one frame_done pulse; depth equals the stub value x+8y.
- Engine latencies 20/1/1/1 cycles -> output order still (0,0),(1,0),(2,0)...; engine 1 eng_ack not issued until pixel (0,0) has retired.
- pix_ready toggled 1010..., plus a 10-cycle low burst -> pix_valid and data held stable while low; no pixel lost or duplicated; 16 unique coordinates.
- run pulsed high one cycle, then low -> full frame completes and scheduler returns to IDLE; run held high -> second frame starts with eng_x=0, eng_y=0 on the cycle after IDLE.
- periph_resetn asserted at pixel 5 -> all outputs 0 asynchronously; after release and run=1, first eng_start carries (0,0).
- Spurious eng_done[2] while occ[2]=0 -> no eng_ack[2], no pix_valid.
